// File: rtl/baccarat_table_fsm.sv
// Baccarat table controller: deals NUM_HANDS player hands and one dealer hand from a
// req/ack card source, applies the third-card rules, lights results and keeps tallies.
module baccarat_table_fsm #(
  parameter int NUM_HANDS = 1,
  parameter int TALLY_W   = 8
) (
  input  logic                   slow_clock,
  input  logic                   resetb,
  input  logic                   start,
  output logic                   card_req,
  input  logic                   card_ack,
  input  logic [3:0]             card_rank,
  output logic [3*NUM_HANDS-1:0] load_pcard,
  output logic [2:0]             load_dcard,
  output logic [4*NUM_HANDS-1:0] pscore,
  output logic [3:0]             dscore,
  output logic [NUM_HANDS-1:0]   player_win,
  output logic [NUM_HANDS-1:0]   dealer_win,
  output logic                   round_done,
  output logic [TALLY_W-1:0]     pwin_tally,
  output logic [TALLY_W-1:0]     dwin_tally,
  output logic [TALLY_W-1:0]     tie_tally,
  output logic [3:0]             dbg_state
);

  // Card handshake: a transfer happens on a rising edge where card_req and card_ack
  // are both high. card_req stays high until that edge, then is low for one cycle.

  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEAL_P1 = 4'd1,
    S_DEAL_D1 = 4'd2,
    S_DEAL_P2 = 4'd3,
    S_DEAL_D2 = 4'd4,
    S_CHECK   = 4'd5,
    S_DRAW_P3 = 4'd6,
    S_DRAW_D3 = 4'd7,
    S_SCORE   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [HW-1:0]          hidx_q, hidx_d;
  logic                   gap_q, gap_d;
  logic [4*NUM_HANDS-1:0] pscore_q, pscore_d;
  logic [3:0]             dscore_q, dscore_d;
  logic [3*NUM_HANDS-1:0] load_p_q, load_p_d;
  logic [2:0]             load_d_q, load_d_d;
  logic [NUM_HANDS-1:0]   pw_q, pw_d, dw_q, dw_d;
  logic [TALLY_W-1:0]     pt_q, pt_d, dt_q, dt_d, tt_q, tt_d;
  logic                   p0_drew_q, p0_drew_d;
  logic [3:0]             p0_val_q, p0_val_d;

  int unsigned hsel;
  logic        last_hand;
  logic        xfer;
  logic        want_card;
  logic [3:0]  cval;
  logic [3:0]  cur_ps;
  logic        drew0_now;
  logic [3:0]  v0_now;
  logic        dealer_draw;
  logic [2:0]  pc, dc, tc;

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic dealer_rule(input logic drew0, input logic [3:0] v,
                                       input logic [3:0] d);
    logic r;
    r = 1'b0;
    if (!drew0) begin
      r = (d <= 4'd5);
    end else begin
      case (d)
        4'd0, 4'd1, 4'd2: r = 1'b1;
        4'd3:    r = (v != 4'd8);
        4'd4:    r = (v >= 4'd2) && (v <= 4'd7);
        4'd5:    r = (v >= 4'd4) && (v <= 4'd7);
        4'd6:    r = (v == 4'd6) || (v == 4'd7);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [TALLY_W-1:0] sat_add(input logic [TALLY_W-1:0] t,
                                                 input logic [2:0] n);
    logic [TALLY_W+2:0] s;
    s = {3'b000, t} + {{TALLY_W{1'b0}}, n};
    if (s > {3'b000, {TALLY_W{1'b1}}}) return {TALLY_W{1'b1}};
    return s[TALLY_W-1:0];
  endfunction

  assign hsel      = 32'(hidx_q);
  assign last_hand = (hidx_q == HW'(NUM_HANDS - 1));
  assign cval      = (card_rank <= 4'd9) ? card_rank : 4'd0;
  assign cur_ps    = pscore_q[4*hsel +: 4];
  assign xfer      = card_req & card_ack;

  // Hand 0 may be drawing on the very cycle the dealer decision is taken (N=1).
  assign drew0_now   = p0_drew_q | ((state_q == S_DRAW_P3) && xfer && (hidx_q == '0));
  assign v0_now      = ((state_q == S_DRAW_P3) && xfer && (hidx_q == '0)) ? cval : p0_val_q;
  assign dealer_draw = dealer_rule(drew0_now, v0_now, dscore_q);

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      hidx_q  <= '0;
    end else begin
      state_q <= state_d;
      hidx_q  <= hidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hidx_d  = hidx_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DEAL_P1;
          hidx_d  = '0;
        end
      end
      S_DEAL_P1: begin
        if (xfer) begin
          if (last_hand) begin
            state_d = S_DEAL_D1;
            hidx_d  = '0;
          end else begin
            hidx_d = hidx_q + HW'(1);
          end
        end
      end
      S_DEAL_D1: if (xfer) state_d = S_DEAL_P2;
      S_DEAL_P2: begin
        if (xfer) begin
          if (last_hand) begin
            state_d = S_DEAL_D2;
            hidx_d  = '0;
          end else begin
            hidx_d = hidx_q + HW'(1);
          end
        end
      end
      S_DEAL_D2: if (xfer) state_d = S_CHECK;
      S_CHECK: begin
        hidx_d = '0;
        if ((pscore_q[3:0] >= 4'd8) || (dscore_q >= 4'd8)) state_d = S_SCORE;
        else state_d = S_DRAW_P3;
      end
      S_DRAW_P3: begin
        if ((cur_ps > 4'd5) || xfer) begin
          if (last_hand) begin
            hidx_d  = '0;
            state_d = dealer_draw ? S_DRAW_D3 : S_SCORE;
          end else begin
            hidx_d = hidx_q + HW'(1);
          end
        end
      end
      S_DRAW_D3: if (xfer) state_d = S_SCORE;
      S_SCORE:   state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    want_card = 1'b0;
    unique case (state_q)
      S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_DRAW_D3: want_card = 1'b1;
      S_DRAW_P3: want_card = (cur_ps <= 4'd5);
      default:   want_card = 1'b0;
    endcase
    card_req   = want_card & ~gap_q;
    round_done = (state_q == S_DONE);
    dbg_state  = state_q;
    load_pcard = load_p_q;
    load_dcard = load_d_q;
    pscore     = pscore_q;
    dscore     = dscore_q;
    player_win = pw_q;
    dealer_win = dw_q;
    pwin_tally = pt_q;
    dwin_tally = dt_q;
    tie_tally  = tt_q;
  end

  always_comb begin
    pc = '0;
    dc = '0;
    tc = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (pscore_q[4*h +: 4] > dscore_q)      pc = pc + 3'd1;
      else if (pscore_q[4*h +: 4] < dscore_q) dc = dc + 3'd1;
      else                                    tc = tc + 3'd1;
    end
  end

  always_comb begin
    gap_d     = xfer;
    pscore_d  = pscore_q;
    dscore_d  = dscore_q;
    load_p_d  = '0;
    load_d_d  = '0;
    pw_d      = pw_q;
    dw_d      = dw_q;
    pt_d      = pt_q;
    dt_d      = dt_q;
    tt_d      = tt_q;
    p0_drew_d = p0_drew_q;
    p0_val_d  = p0_val_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      pscore_d  = '0;
      dscore_d  = '0;
      pw_d      = '0;
      dw_d      = '0;
      p0_drew_d = 1'b0;
      p0_val_d  = '0;
    end
    if (xfer) begin
      unique case (state_q)
        S_DEAL_P1: begin
          pscore_d[4*hsel +: 4] = add_mod10(cur_ps, cval);
          load_p_d[3*hsel]      = 1'b1;
        end
        S_DEAL_P2: begin
          pscore_d[4*hsel +: 4] = add_mod10(cur_ps, cval);
          load_p_d[3*hsel+1]    = 1'b1;
        end
        S_DRAW_P3: begin
          pscore_d[4*hsel +: 4] = add_mod10(cur_ps, cval);
          load_p_d[3*hsel+2]    = 1'b1;
          if (hidx_q == '0) begin
            p0_drew_d = 1'b1;
            p0_val_d  = cval;
          end
        end
        S_DEAL_D1: begin
          dscore_d    = add_mod10(dscore_q, cval);
          load_d_d[0] = 1'b1;
        end
        S_DEAL_D2: begin
          dscore_d    = add_mod10(dscore_q, cval);
          load_d_d[1] = 1'b1;
        end
        S_DRAW_D3: begin
          dscore_d    = add_mod10(dscore_q, cval);
          load_d_d[2] = 1'b1;
        end
        default: ;
      endcase
    end
    if (state_q == S_SCORE) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        pw_d[h] = (pscore_q[4*h +: 4] >= dscore_q);
        dw_d[h] = (dscore_q >= pscore_q[4*h +: 4]);
      end
      pt_d = sat_add(pt_q, pc);
      dt_d = sat_add(dt_q, dc);
      tt_d = sat_add(tt_q, tc);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      gap_q     <= 1'b0;
      pscore_q  <= '0;
      dscore_q  <= '0;
      load_p_q  <= '0;
      load_d_q  <= '0;
      pw_q      <= '0;
      dw_q      <= '0;
      pt_q      <= '0;
      dt_q      <= '0;
      tt_q      <= '0;
      p0_drew_q <= 1'b0;
      p0_val_q  <= '0;
    end else begin
      gap_q     <= gap_d;
      pscore_q  <= pscore_d;
      dscore_q  <= dscore_d;
      load_p_q  <= load_p_d;
      load_d_q  <= load_d_d;
      pw_q      <= pw_d;
      dw_q      <= dw_d;
      pt_q      <= pt_d;
      dt_q      <= dt_d;
      tt_q      <= tt_d;
      p0_drew_q <= p0_drew_d;
      p0_val_q  <= p0_val_d;
    end
  end

endmodule

// File: tb/tb_baccarat_table_fsm.sv
// Bench for baccarat_table_fsm: instance 0 (1 hand, 2-bit tallies), instance 1 (2 hands),
// each fed by a card deck queue, checked against a rule-level round model.
module tb_baccarat_table_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb_s[2];
  logic       start_s[2];
  logic       ack_s[2];
  logic [3:0] rank_s[2];

  logic       a_req, a_done;
  logic [2:0] a_lp, a_ld;
  logic [3:0] a_ps, a_ds, a_st;
  logic [0:0] a_pw, a_dw;
  logic [1:0] a_pt, a_dt, a_tt;

  logic       b_req, b_done;
  logic [5:0] b_lp;
  logic [2:0] b_ld;
  logic [7:0] b_ps;
  logic [3:0] b_ds, b_st;
  logic [1:0] b_pw, b_dw;
  logic [7:0] b_pt, b_dt, b_tt;

  baccarat_table_fsm #(.NUM_HANDS(1), .TALLY_W(2)) u_a (
    .slow_clock(clk), .resetb(resetb_s[0]), .start(start_s[0]), .card_req(a_req),
    .card_ack(ack_s[0]), .card_rank(rank_s[0]), .load_pcard(a_lp), .load_dcard(a_ld),
    .pscore(a_ps), .dscore(a_ds), .player_win(a_pw), .dealer_win(a_dw),
    .round_done(a_done), .pwin_tally(a_pt), .dwin_tally(a_dt), .tie_tally(a_tt),
    .dbg_state(a_st)
  );

  baccarat_table_fsm #(.NUM_HANDS(2), .TALLY_W(8)) u_b (
    .slow_clock(clk), .resetb(resetb_s[1]), .start(start_s[1]), .card_req(b_req),
    .card_ack(ack_s[1]), .card_rank(rank_s[1]), .load_pcard(b_lp), .load_dcard(b_ld),
    .pscore(b_ps), .dscore(b_ds), .player_win(b_pw), .dealer_win(b_dw),
    .round_done(b_done), .pwin_tally(b_pt), .dwin_tally(b_dt), .tie_tally(b_tt),
    .dbg_state(b_st)
  );

  logic        o_req[2], o_done[2];
  logic [11:0] o_lp[2];
  logic [2:0]  o_ld[2];
  logic [15:0] o_ps[2];
  logic [3:0]  o_ds[2], o_pw[2], o_dw[2];
  logic [7:0]  o_pt[2], o_dt[2], o_tt[2];

  assign o_req[0] = a_req;          assign o_req[1] = b_req;
  assign o_done[0] = a_done;        assign o_done[1] = b_done;
  assign o_lp[0] = {9'b0, a_lp};    assign o_lp[1] = {6'b0, b_lp};
  assign o_ld[0] = a_ld;            assign o_ld[1] = b_ld;
  assign o_ps[0] = {12'b0, a_ps};   assign o_ps[1] = {8'b0, b_ps};
  assign o_ds[0] = a_ds;            assign o_ds[1] = b_ds;
  assign o_pw[0] = {3'b0, a_pw};    assign o_pw[1] = {2'b0, b_pw};
  assign o_dw[0] = {3'b0, a_dw};    assign o_dw[1] = {2'b0, b_dw};
  assign o_pt[0] = {6'b0, a_pt};    assign o_pt[1] = b_pt;
  assign o_dt[0] = {6'b0, a_dt};    assign o_dt[1] = b_dt;
  assign o_tt[0] = {6'b0, a_tt};    assign o_tt[1] = b_tt;

  int errors = 0;
  int checks = 0;

  logic [3:0]  deck0[$];
  logic [3:0]  deck1[$];
  logic        ack_en[2];
  logic        xfer_prev[2];
  logic [11:0] pmask_seen[2];
  logic [2:0]  dmask_seen[2];
  int          pcnt[2], dcnt[2];

  int          rc[$];
  int          m_p[4];
  int          m_d, m_used, m_pc, m_dc, m_tc;
  logic [11:0] m_pmask;
  logic [2:0]  m_dmask;
  logic [3:0]  m_pw, m_dw;
  int          e_pt[2], e_dt[2], e_tt[2];

  function automatic int cv(input int r);
    return (r <= 9) ? r : 0;
  endfunction

  // Deck model: serves queued cards only while card_req is high, throws junk acks otherwise.
  task automatic deck_step(input int w);
    int sz;
    if (xfer_prev[w]) begin
      checks++;
      if (o_req[w] !== 1'b0) begin
        errors++;
        $display("FAIL req_gap[%0d]: card_req=%b after transfer, required 0", w, o_req[w]);
      end
      if (w == 0) void'(deck0.pop_front());
      else void'(deck1.pop_front());
    end
    pmask_seen[w] = pmask_seen[w] | o_lp[w];
    dmask_seen[w] = dmask_seen[w] | o_ld[w];
    pcnt[w] += $countones(o_lp[w]);
    dcnt[w] += $countones(o_ld[w]);
    sz = (w == 0) ? deck0.size() : deck1.size();
    if (o_req[w] === 1'b1) begin
      if (ack_en[w] && sz > 0) begin
        ack_s[w]     = 1'b1;
        rank_s[w]    = (w == 0) ? deck0[0] : deck1[0];
        xfer_prev[w] = 1'b1;
      end else begin
        ack_s[w]     = 1'b0;
        xfer_prev[w] = 1'b0;
      end
    end else begin
      ack_s[w]     = ($urandom_range(0, 3) == 0);
      rank_s[w]    = 4'($urandom_range(1, 13));
      xfer_prev[w] = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    deck_step(0);
    deck_step(1);
  endtask

  task automatic model_round(input int n);
    int idx, v, c;
    bit p0_drew, dd;
    idx = 0; m_pmask = '0; m_dmask = '0;
    for (int h = 0; h < n; h++) begin
      m_p[h] = cv(rc[idx]); idx++; m_pmask[3*h] = 1'b1;
    end
    m_d = cv(rc[idx]); idx++; m_dmask[0] = 1'b1;
    for (int h = 0; h < n; h++) begin
      m_p[h] = (m_p[h] + cv(rc[idx])) % 10; idx++; m_pmask[3*h+1] = 1'b1;
    end
    m_d = (m_d + cv(rc[idx])) % 10; idx++; m_dmask[1] = 1'b1;
    if (m_p[0] < 8 && m_d < 8) begin
      p0_drew = 0; v = 0;
      for (int h = 0; h < n; h++) begin
        if (m_p[h] <= 5) begin
          c = cv(rc[idx]); idx++;
          m_p[h] = (m_p[h] + c) % 10;
          m_pmask[3*h+2] = 1'b1;
          if (h == 0) begin p0_drew = 1; v = c; end
        end
      end
      if (!p0_drew) dd = (m_d <= 5);
      else if (m_d <= 2) dd = 1;
      else if (m_d == 3) dd = (v != 8);
      else if (m_d == 4) dd = (v >= 2 && v <= 7);
      else if (m_d == 5) dd = (v >= 4 && v <= 7);
      else if (m_d == 6) dd = (v == 6 || v == 7);
      else dd = 0;
      if (dd) begin
        m_d = (m_d + cv(rc[idx])) % 10; idx++; m_dmask[2] = 1'b1;
      end
    end
    m_used = idx;
    m_pc = 0; m_dc = 0; m_tc = 0; m_pw = '0; m_dw = '0;
    for (int h = 0; h < n; h++) begin
      if (m_p[h] > m_d) begin m_pc++; m_pw[h] = 1'b1; end
      else if (m_p[h] < m_d) begin m_dc++; m_dw[h] = 1'b1; end
      else begin m_tc++; m_pw[h] = 1'b1; m_dw[h] = 1'b1; end
    end
  endtask

  task automatic prep_round(input int w);
    int mx;
    mx = (w == 0) ? 3 : 255;
    model_round(w + 1);
    pmask_seen[w] = '0; dmask_seen[w] = '0; pcnt[w] = 0; dcnt[w] = 0;
    for (int i = 0; i < m_used; i++) begin
      if (w == 0) deck0.push_back(4'(rc[i]));
      else deck1.push_back(4'(rc[i]));
    end
    e_pt[w] = (e_pt[w] + m_pc > mx) ? mx : e_pt[w] + m_pc;
    e_dt[w] = (e_dt[w] + m_dc > mx) ? mx : e_dt[w] + m_dc;
    e_tt[w] = (e_tt[w] + m_tc > mx) ? mx : e_tt[w] + m_tc;
  endtask

  task automatic kick(input int w);
    start_s[w] = 1'b1;
    tick();
    start_s[w] = 1'b0;
  endtask

  task automatic finish_round(input int w, input string name);
    int cyc;
    logic [15:0] eps;
    int sz;
    cyc = 0;
    while (o_done[w] !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    checks++;
    if (o_done[w] !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: round_done=%b after %0d cycles, required 1", name, o_done[w], cyc);
    end
    eps = '0;
    for (int h = 0; h <= w; h++) eps[4*h +: 4] = 4'(m_p[h]);
    checks++;
    if (o_ps[w] !== eps || o_ds[w] !== 4'(m_d)) begin
      errors++;
      $display("FAIL %s scores: pscore=%h dscore=%0d, required pscore=%h dscore=%0d",
               name, o_ps[w], o_ds[w], eps, m_d);
    end
    checks++;
    if (o_pw[w] !== m_pw || o_dw[w] !== m_dw) begin
      errors++;
      $display("FAIL %s lights: player_win=%b dealer_win=%b, required %b %b",
               name, o_pw[w], o_dw[w], m_pw, m_dw);
    end
    checks++;
    if (o_pt[w] !== 8'(e_pt[w]) || o_dt[w] !== 8'(e_dt[w]) || o_tt[w] !== 8'(e_tt[w])) begin
      errors++;
      $display("FAIL %s tallies: p=%0d d=%0d t=%0d, required p=%0d d=%0d t=%0d",
               name, o_pt[w], o_dt[w], o_tt[w], e_pt[w], e_dt[w], e_tt[w]);
    end
    checks++;
    if (pmask_seen[w] !== m_pmask || dmask_seen[w] !== m_dmask ||
        pcnt[w] != $countones(m_pmask) || dcnt[w] != $countones(m_dmask)) begin
      errors++;
      $display("FAIL %s strobes: pmask=%b(%0d) dmask=%b(%0d), required pmask=%b dmask=%b once each",
               name, pmask_seen[w], pcnt[w], dmask_seen[w], dcnt[w], m_pmask, m_dmask);
    end
    sz = (w == 0) ? deck0.size() : deck1.size();
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s cards_used: %0d cards left in deck, required 0", name, sz);
    end
  endtask

  task automatic play(input int w, input string name);
    prep_round(w);
    kick(w);
    finish_round(w, name);
  endtask

  task automatic check_zero(input int w, input string name);
    checks++;
    if ({o_req[w], o_done[w], o_lp[w], o_ld[w], o_ps[w], o_ds[w], o_pw[w], o_dw[w]} !== '0) begin
      errors++;
      $display("FAIL %s outputs: req=%b done=%b lp=%b ld=%b ps=%h ds=%h pw=%b dw=%b, required all 0",
               name, o_req[w], o_done[w], o_lp[w], o_ld[w], o_ps[w], o_ds[w], o_pw[w], o_dw[w]);
    end
    checks++;
    if ({o_pt[w], o_dt[w], o_tt[w]} !== '0) begin
      errors++;
      $display("FAIL %s tallies: p=%0d d=%0d t=%0d, required 0", name, o_pt[w], o_dt[w], o_tt[w]);
    end
  endtask

  task automatic test_reset();
    resetb_s[0] = 1'b0; resetb_s[1] = 1'b0;
    tick(); tick();
    resetb_s[0] = 1'b1; resetb_s[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      e_pt[w] = 0; e_dt[w] = 0; e_tt[w] = 0;
    end
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
  endtask

  task automatic test_natural();
    rc = '{9, 3, 13, 2};
    play(0, "natural");
  endtask

  task automatic test_third_card();
    rc = '{2, 3, 1, 3, 6, 1};
    play(0, "third_card");
  endtask

  task automatic test_tie();
    rc = '{7, 7, 10, 10};
    play(0, "tie");
  endtask

  task automatic test_two_hands();
    rc = '{6, 2, 4, 12, 2, 11, 5, 3};
    play(1, "two_hands");
  endtask

  task automatic test_stall_and_start();
    rc = '{9, 3, 13, 2};
    ack_en[0] = 1'b0;
    prep_round(0);
    kick(0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_req[0] !== 1'b1 || o_lp[0] !== '0 || o_ld[0] !== '0) begin
        errors++;
        $display("FAIL stall[%0d]: card_req=%b lp=%b ld=%b, required req=1 no strobes",
                 i, o_req[0], o_lp[0], o_ld[0]);
      end
      tick();
    end
    ack_en[0] = 1'b1;
    tick(); tick(); tick();
    kick(0);
    finish_round(0, "stall_start");
  endtask

  task automatic test_saturation();
    rc = '{9, 3, 13, 2};
    play(0, "saturate_1");
    rc = '{9, 3, 13, 2};
    play(0, "saturate_2");
  endtask

  task automatic test_mid_reset();
    rc.delete();
    for (int i = 0; i < 9; i++) rc.push_back($urandom_range(1, 13));
    prep_round(0);
    kick(0);
    tick(); tick(); tick(); tick();
    resetb_s[0] = 1'b0;
    tick();
    resetb_s[0] = 1'b1;
    e_pt[0] = 0; e_dt[0] = 0; e_tt[0] = 0;
    check_zero(0, "mid_reset");
    deck0.delete();
    ack_s[0] = 1'b0;
    xfer_prev[0] = 1'b0;
    rc = '{2, 3, 1, 3, 6, 1};
    play(0, "after_reset");
  endtask

  task automatic test_back_to_back(input int w, input int rounds);
    for (int r = 0; r < rounds; r++) begin
      rc.delete();
      for (int i = 0; i < 9; i++) rc.push_back($urandom_range(1, 13));
      play(w, $sformatf("random_w%0d_r%0d", w, r));
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      resetb_s[w] = 1'b0; start_s[w] = 1'b0; ack_s[w] = 1'b0; rank_s[w] = 4'd1;
      ack_en[w] = 1'b1; xfer_prev[w] = 1'b0;
      pmask_seen[w] = '0; dmask_seen[w] = '0; pcnt[w] = 0; dcnt[w] = 0;
    end
    test_reset();
    test_natural();
    test_third_card();
    test_tie();
    test_two_hands();
    test_stall_and_start();
    test_saturation();
    test_mid_reset();
    test_back_to_back(0, 15);
    test_back_to_back(1, 25);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
